// File: rtl/uart_periph_pkg.sv
`default_nettype none
// ============================================================================
// Module     : uart_periph_pkg
// Description: Shared constants for the memory-mapped UART: register offsets,
//              CON bit positions, 2-bit FSM state encodings and the baud
//              divider helper.
// Revision   : 1.0 - initial release
// ============================================================================
package uart_periph_pkg;

  // Byte offsets of the three registers relative to BASE_ADDR
  localparam logic [31:0] OFF_TXD = 32'h0000_0000;
  localparam logic [31:0] OFF_RXD = 32'h0000_0004;
  localparam logic [31:0] OFF_CON = 32'h0000_0008;

  // Word indices used by the decoder (address bits [1:0] are ignored)
  localparam logic [29:0] WORD_TXD = OFF_TXD[31:2];
  localparam logic [29:0] WORD_RXD = OFF_RXD[31:2];
  localparam logic [29:0] WORD_CON = OFF_CON[31:2];

  // CON register bit positions
  localparam int CON_TX_BUSY   = 0;
  localparam int CON_RX_VALID  = 1;
  localparam int CON_RX_OVR    = 2;
  localparam int CON_RX_FERR   = 3;
  localparam int CON_TX_DONE   = 4;
  localparam int CON_LOOPBACK  = 5;

  // Shared by the TX and RX state machines
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Clock cycles per serial bit
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module     : uart_tx_engine
// Description: 8N1 transmitter. A start request while idle loads the byte and
//              runs START, 8 DATA bits (LSB first) and STOP, each held for
//              BAUD_DIV clocks. The serial output is registered.
// Revision   : 1.0 - initial release
// ============================================================================
module uart_tx_engine
  import uart_periph_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,       // asynchronous, active-low
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done_pulse,
  output logic       tx
);

  localparam int unsigned      CNT_W      = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             w_expire;

  assign w_expire   = (cnt_q == '0);
  assign busy       = (state_q != ST_IDLE);
  assign done_pulse = (state_q == ST_STOP) && w_expire;
  assign tx         = tx_q;

  // Next-state logic: the counter only ever counts down to zero and is
  // reloaded on every state change, so the line level written here is held
  // for exactly BAUD_DIV clocks.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_START;
          cnt_d   = CNT_RELOAD;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (w_expire) begin
          state_d = ST_DATA;
          cnt_d   = CNT_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (w_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any frame and parks the line high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_bus_peripheral.sv
`default_nettype none
// ============================================================================
// Module     : uart_bus_peripheral
// Description: Memory-mapped 8N1 UART on the CPU data bus. Registers TXD
//              (BASE), RXD (BASE+4) and CON (BASE+8); zero-wait combinational
//              read data, TX engine sub-module, RX engine and register file.
//              Optional feature macro: UART_PERIPH_LOOPBACK_EN (CON[5] routes
//              uart_tx into the RX synchroniser).
// Revision   : 1.0 - initial release
// ============================================================================
module uart_bus_peripheral
  import uart_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0018,
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 9600
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        Hit,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);

  localparam int unsigned      BAUD_DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned      CNT_W      = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(BAUD_DIV / 2);

  // ---------------------------------------------------------------- decode
  logic [29:0] w_word;
  logic        w_sel_txd, w_sel_rxd, w_sel_con;
  logic        w_wr_txd, w_wr_con, w_rd_rxd;

  assign w_word    = Address[31:2] - BASE_ADDR[31:2];
  assign w_sel_txd = (w_word == WORD_TXD);
  assign w_sel_rxd = (w_word == WORD_RXD);
  assign w_sel_con = (w_word == WORD_CON);
  assign Hit       = w_sel_txd | w_sel_rxd | w_sel_con;
  assign w_wr_txd  = MemWrite & w_sel_txd;
  assign w_wr_con  = MemWrite & w_sel_con;
  assign w_rd_rxd  = MemRead  & w_sel_rxd;

  // Address low bits and upper store data have no meaning here
  logic unused_bits;
  assign unused_bits = ^{Address[1:0], Write_data[31:8]};

  // ------------------------------------------------------------- TX engine
  logic w_tx_busy, w_tx_done_pulse, w_tx_start;

  // A store to TXD while a frame is in flight is dropped
  assign w_tx_start = w_wr_txd & ~w_tx_busy;

  uart_tx_engine #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk        (clk),
    .reset      (reset),
    .start      (w_tx_start),
    .data       (Write_data[7:0]),
    .busy       (w_tx_busy),
    .done_pulse (w_tx_done_pulse),
    .tx         (uart_tx)
  );

  // ------------------------------------------------------- loopback select
  logic w_rx_pin;
  logic w_loop;

`ifdef UART_PERIPH_LOOPBACK_EN
  logic loop_q;

  // CON[5] is a plain read/write control bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loop_q <= 1'b0;
    end else if (w_wr_con) begin
      loop_q <= Write_data[CON_LOOPBACK];
    end
  end

  assign w_loop   = loop_q;
  assign w_rx_pin = loop_q ? uart_tx : uart_rx;
`else
  assign w_loop   = 1'b0;
  assign w_rx_pin = uart_rx;
`endif

  // ------------------------------------------------------------- RX engine
  logic [1:0]       sync_q;
  logic             w_rx_s;
  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             w_rx_expire;
  logic             w_rx_ok, w_rx_err;

  assign w_rx_s      = sync_q[1];
  assign w_rx_expire = (rx_cnt_q == '0);

  // Two-flop synchroniser for the asynchronous serial input; idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], w_rx_pin};
    end
  end

  // RX next-state: half-bit wait qualifies the start bit, then every sample
  // lands near a bit centre
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = (rx_cnt_q != '0) ? rx_cnt_q - 1'b1 : rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    w_rx_ok    = 1'b0;
    w_rx_err   = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (!w_rx_s) begin
          rx_state_d = ST_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      ST_START: begin
        if (w_rx_expire) begin
          if (!w_rx_s) begin
            rx_state_d = ST_DATA;
            rx_cnt_d   = CNT_RELOAD;
            rx_bit_d   = 3'd0;
          end else begin
            // line bounced back high: treat as noise, raise nothing
            rx_state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (w_rx_expire) begin
          rx_shift_d = {w_rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = CNT_RELOAD;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_rx_expire) begin
          rx_state_d = ST_IDLE;
          w_rx_ok    = w_rx_s;
          w_rx_err   = ~w_rx_s;
        end
      end
      default: begin
        rx_state_d = ST_IDLE;
      end
    endcase
  end

  // RX state registers; reset discards any partial byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // --------------------------------------------------------- register file
  logic [7:0] txd_q, txd_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       rx_ferr_q, rx_ferr_d;
  logic       tx_done_q, tx_done_d;
  logic       irq_q;

  // Status updates: clears are applied first so that a hardware set on the
  // same edge always wins
  always_comb begin
    txd_d      = txd_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    rx_ferr_d  = rx_ferr_q;
    tx_done_d  = tx_done_q;

    if (w_tx_start) begin
      txd_d     = Write_data[7:0];
      tx_done_d = 1'b0;
    end
    if (w_rd_rxd) begin
      rx_valid_d = 1'b0;
    end
    if (w_wr_con) begin
      if (Write_data[CON_RX_OVR])  rx_ovr_d  = 1'b0;
      if (Write_data[CON_RX_FERR]) rx_ferr_d = 1'b0;
      if (Write_data[CON_TX_DONE]) tx_done_d = 1'b0;
    end

    if (w_tx_done_pulse) begin
      tx_done_d = 1'b1;
    end
    if (w_rx_ok) begin
      rx_byte_d  = rx_shift_q;
      rx_valid_d = 1'b1;
      // a byte read out on this very edge is not lost, so no overrun
      if (rx_valid_q && !w_rd_rxd) begin
        rx_ovr_d = 1'b1;
      end
    end
    if (w_rx_err) begin
      rx_ferr_d = 1'b1;
    end
  end

  // Register file storage; irq tracks the next status so it is level-true
  // with the flags it reports
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txd_q      <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      txd_q      <= txd_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
      tx_done_q  <= tx_done_d;
      irq_q      <= rx_valid_d | tx_done_d;
    end
  end

  assign irq = irq_q;

  // Zero-wait read mux; drives zero whenever the address is not ours
  always_comb begin
    Read_data = 32'h0000_0000;
    if (w_sel_txd) begin
      Read_data = {24'h000000, txd_q};
    end else if (w_sel_rxd) begin
      Read_data = {24'h000000, rx_byte_q};
    end else if (w_sel_con) begin
      Read_data = {26'h0, w_loop, tx_done_q, rx_ferr_q, rx_ovr_q,
                   rx_valid_q, w_tx_busy};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_peripheral.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : tb_uart_bus_peripheral
// Description: Self-checking bench. Bus reads and serial TX frames are
//              compared by monitors against expectations queued from a
//              register-level model of the UART.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_uart_bus_peripheral;

  localparam logic [31:0] BASE  = 32'h4000_0018;
  localparam logic [31:0] A_TXD = BASE;
  localparam logic [31:0] A_RXD = BASE + 32'd4;
  localparam logic [31:0] A_CON = BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Address = 32'h0;
  logic [31:0] Write_data = 32'h0;
  logic        uart_rx = 1'b1;
  wire  [31:0] Read_data;
  wire         Hit;
  wire         uart_tx;
  wire         irq;

  always #5 clk = ~clk;

  uart_bus_peripheral #(
    .BASE_ADDR (BASE),
    .CLK_FREQ  (16),
    .BAUD      (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .Hit        (Hit),
    .uart_tx    (uart_tx),
    .uart_rx    (uart_rx),
    .irq        (irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  bit         m_rxv, m_ov, m_fe, m_txdone, m_loop;
  logic [7:0] m_rxbyte, m_txd;

  function automatic logic [31:0] exp_con(input bit busy);
    return {26'h0, m_loop, m_txdone, m_fe, m_ov, m_rxv, busy};
  endfunction

  task automatic model_reset();
    m_rxv = 0; m_ov = 0; m_fe = 0; m_txdone = 0; m_loop = 0;
    m_rxbyte = 8'h00; m_txd = 8'h00;
  endtask

  task automatic model_rx_ok(input logic [7:0] b);
    if (m_rxv) m_ov = 1;
    m_rxbyte = b;
    m_rxv    = 1;
  endtask

  // ----------------------------------------------------------- scoreboards
  logic [31:0] q_rd_data[$];
  bit          q_rd_hit[$];
  bit          q_rd_irq[$];
  string       q_rd_name[$];
  logic [7:0]  q_tx[$];
  bit          tx_ignore = 0;
  int          tx_falls  = 0;

  always @(negedge uart_tx) tx_falls++;

  // Bus read monitor: compares whatever the DUT shows during a read cycle
  always @(negedge clk) begin
    if (MemRead) begin
      if (q_rd_name.size() == 0) begin
        check("rd_unexpected", 32'h1, 32'h0);
      end else begin
        string       nm;
        logic [31:0] d;
        bit          h, iq;
        nm = q_rd_name.pop_front();
        d  = q_rd_data.pop_front();
        h  = q_rd_hit.pop_front();
        iq = q_rd_irq.pop_front();
        check({nm, ".data"}, Read_data, d);
        check({nm, ".hit"}, {31'h0, Hit}, {31'h0, h});
        check({nm, ".irq"}, {31'h0, irq}, {31'h0, iq});
      end
    end
  end

  // Serial TX monitor: decodes each frame at bit centres
  initial begin
    forever begin
      logic [9:0] fr;
      bit         ign;
      bit         have;
      @(negedge uart_tx);
      ign  = tx_ignore;
      have = (q_tx.size() != 0);
      if (!ign && !have) check("tx_unexpected_frame", 32'h1, 32'h0);
      repeat (8) @(posedge clk);
      #1 fr[0] = uart_tx;
      for (int k = 1; k < 10; k++) begin
        repeat (16) @(posedge clk);
        #1 fr[k] = uart_tx;
      end
      if (!ign && have) begin
        logic [7:0] e;
        e = q_tx.pop_front();
        check("tx_start_bit", {31'h0, fr[0]}, 32'h0);
        check("tx_byte", {24'h0, fr[8:1]}, {24'h0, e});
        check("tx_stop_bit", {31'h0, fr[9]}, 32'h1);
      end
    end
  end

  // ------------------------------------------------------------ bus tasks
  // Every task starts and ends 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1; Address = a; Write_data = d;
    @(posedge clk);
    #1 MemWrite = 0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] d, input bit h, input string nm);
    q_rd_data.push_back(d);
    q_rd_hit.push_back(h);
    q_rd_irq.push_back(m_rxv | m_txdone);
    q_rd_name.push_back(nm);
    MemRead = 1; Address = a;
    @(posedge clk);
    #1 MemRead = 0;
  endtask

  task automatic read_con(input string nm);
    bus_read(A_CON, exp_con(0), 1, nm);
  endtask

  task automatic read_rxd(input string nm);
    bus_read(A_RXD, {24'h0, m_rxbyte}, 1, nm);
    m_rxv = 0;
  endtask

  task automatic wr_con(input logic [31:0] v);
    bus_write(A_CON, v);
    if (v[2]) m_ov = 0;
    if (v[3]) m_fe = 0;
    if (v[4]) m_txdone = 0;
`ifdef UART_PERIPH_LOOPBACK_EN
    m_loop = v[5];
`endif
  endtask

  // Full TX transaction; optionally a second TXD store lands on the STOP exit edge
  task automatic do_tx(input logic [7:0] b, input bit collide);
    q_tx.push_back(b);
    bus_write(A_TXD, {24'h0, b});
    m_txdone = 0;
    m_txd    = b;
    bus_read(A_CON, exp_con(1), 1, "con_busy_start");
    idle(158);
    if (collide) bus_write(A_TXD, {24'h0, ~b});
    else         bus_read(A_CON, exp_con(1), 1, "con_busy_last");
    m_txdone = 1;
    read_con("con_tx_done");
    bus_read(A_TXD, {24'h0, m_txd}, 1, "txd_readback");
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop_bit);
    uart_rx = 0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(16);
    end
    uart_rx = stop_bit;
    idle(16);
    uart_rx = 1;
  endtask

  task automatic rx_good(input logic [7:0] b);
    send_rx(b, 1);
    model_rx_ok(b);
    idle(2);
    read_con("con_after_rx");
  endtask

  task automatic rx_bad(input logic [7:0] b);
    send_rx(b, 0);
    m_fe = 1;
    idle(20);
    read_con("con_after_ferr");
    read_rxd("rxd_after_ferr");
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] b;
    int         snap;
    model_reset();
    #22;
    check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
    check("reset_irq", {31'h0, irq}, 32'h0);
    reset = 1;
    @(posedge clk); #1;

    read_con("reset_con");
    bus_read(A_TXD, 32'h0, 1, "reset_txd");
    bus_read(A_RXD, 32'h0, 1, "reset_rxd");
    bus_read(BASE + 32'd12, 32'h0, 0, "miss_above");
    bus_read(BASE - 32'd4, 32'h0, 0, "miss_below");
    bus_read(A_CON + 32'd3, exp_con(0), 1, "con_low_bits_ignored");

    // Transmit 0xA5
    do_tx(8'hA5, 0);

    // Receive 0x3C, read it, flag drops
    rx_good(8'h3C);
    read_rxd("rxd_3c");
    read_con("con_after_rxd_read");

    // Overrun, then W1C
    rx_good(8'h11);
    rx_good(8'h22);
    read_rxd("rxd_overrun");
    wr_con(32'h0000_0004);
    read_con("con_ovr_cleared");

    // RXD read on the same edge as a new byte completes
    rx_good(8'h5A);
    fork
      send_rx(8'hC3, 1);
      begin
        idle(155);
        bus_read(A_RXD, {24'h0, m_rxbyte}, 1, "rxd_same_edge");
      end
    join
    m_rxbyte = 8'hC3;
    m_rxv    = 1;
    idle(2);
    read_con("con_same_edge");
    read_rxd("rxd_c3");

    // Framing error leaves the byte alone
    rx_bad(8'h55);
    wr_con(32'h0000_0008);
    read_con("con_ferr_cleared");

    // Short low glitch raises nothing
    uart_rx = 0;
    idle(8);
    uart_rx = 1;
    idle(40);
    read_con("con_after_glitch");

    // TXD store on the STOP exit edge is dropped
    do_tx(8'($urandom), 1);
    wr_con(32'h0000_0010);
    read_con("con_done_cleared");

    // Reset in the middle of a frame
    tx_ignore = 1;
    bus_write(A_TXD, 32'h0000_00F0);
    m_txd = 8'hF0;
    bus_write(A_TXD, 32'h0000_000F);
    bus_read(A_TXD, 32'h0000_00F0, 1, "txd_busy_write_ignored");
    idle(40);
    reset = 0;
    idle(3);
    check("tx_high_in_reset", {31'h0, uart_tx}, 32'h1);
    snap  = tx_falls;
    reset = 1;
    model_reset();
    idle(1);
    read_con("con_after_reset");
    bus_read(A_TXD, 32'h0, 1, "txd_after_reset");
    idle(200);
    check("no_tx_after_reset", tx_falls - snap, 32'h0);
    check("tx_idle_after_reset", {31'h0, uart_tx}, 32'h1);
    tx_ignore = 0;

    // Random traffic
    for (int it = 0; it < 12; it++) begin
      b = 8'($urandom);
      case ($urandom_range(0, 3))
        0: do_tx(b, 1'($urandom_range(0, 1)));
        1: rx_good(b);
        2: rx_bad(b);
        default: begin
          read_rxd("rxd_random");
          wr_con($urandom & 32'hFFFF_FFDF);
          read_con("con_random_w1c");
        end
      endcase
    end

    // Loopback control bit
    wr_con(32'h0000_0020);
    read_con("con_loopback_bit");
`ifdef UART_PERIPH_LOOPBACK_EN
    q_tx.push_back(8'h9E);
    bus_write(A_TXD, 32'h0000_009E);
    m_txdone = 0;
    m_txd    = 8'h9E;
    idle(200);
    m_txdone = 1;
    model_rx_ok(8'h9E);
    read_con("con_loopback_rx");
    read_rxd("rxd_loopback");
    wr_con(32'h0000_0000);
    read_con("con_loopback_off");
`endif

    idle(200);
    check("tx_queue_drained", q_tx.size(), 32'h0);
    check("rd_queue_drained", q_rd_name.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Run-time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
